// File: rtl/sar_converter.sv
// sar_converter: behavioural successive-approximation converter.
// Answers a level-sensitive soc/eoc handshake and binary-searches vin over N
// clock steps, one result bit per clock. The result appears on x on the same
// edge that eoc rises.
//
// Optional feature (macro SAR_SAMPLE_HOLD_EN):
//   defined   - vin is captured into a held register on the IDLE->ARMED edge
//               and every search step compares against that captured value.
//   undefined - there is no held register; each search step compares against
//               the live vin seen on that clock.

module sar_converter #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         soc,
    input  logic [N-1:0] vin,
    output logic         eoc,
    output logic [N-1:0] x
);

    // Mask value loaded at the start of a search: only the MSB is set.
    localparam logic [N-1:0] MSB_MASK = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_CONV  = 2'd2
    } state_t;

    state_t       state_reg;
    state_t       state_next;
    logic [N-1:0] result_reg;
    logic [N-1:0] result_next;
    logic [N-1:0] mask_reg;
    logic [N-1:0] mask_next;
    logic [N-1:0] x_reg;
    logic [N-1:0] x_next;
    logic         eoc_reg;
    logic         eoc_next;

    // Value the search compares against, and the candidate for this step.
    logic [N-1:0] ref_val;
    logic [N-1:0] trial;
    logic [N-1:0] step_result;

`ifdef SAR_SAMPLE_HOLD_EN
    logic [N-1:0] held_reg;
    logic [N-1:0] held_next;

    // Sample-and-hold register: holds the vin captured at the start of a request.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            held_reg <= '0;
        end else begin
            held_reg <= held_next;
        end
    end

    assign ref_val = held_reg;
`else
    assign ref_val = vin;
`endif

    // Candidate bit pattern for the current step: the bits kept so far plus
    // the bit under test.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_trial
            assign trial[gi] = result_reg[gi] | mask_reg[gi];
        end
    endgenerate

    // Keep the tested bit only when the candidate does not exceed the reference.
    // Both operands are N-bit unsigned, so no overflow is possible.
    assign step_result = (trial <= ref_val) ? trial : result_reg;

    // State and datapath registers; reset returns to idle with eoc high and x cleared.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_reg  <= ST_IDLE;
            result_reg <= '0;
            mask_reg   <= '0;
            x_reg      <= '0;
            eoc_reg    <= 1'b1;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            mask_reg   <= mask_next;
            x_reg      <= x_next;
            eoc_reg    <= eoc_next;
        end
    end

    // Next-state and datapath control for the handshake and the bit search.
    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        mask_next   = mask_reg;
        x_next      = x_reg;
        eoc_next    = eoc_reg;
`ifdef SAR_SAMPLE_HOLD_EN
        held_next   = held_reg;
`endif

        unique case (state_reg)
            ST_IDLE: begin
                eoc_next = 1'b1;
                if (soc) begin
                    // Accept the request; busy is signalled one clock later.
                    eoc_next   = 1'b0;
                    state_next = ST_ARMED;
`ifdef SAR_SAMPLE_HOLD_EN
                    held_next  = vin;
`endif
                end
            end

            ST_ARMED: begin
                // The search starts only once the requester has dropped soc,
                // so a requester that holds soc can stall here indefinitely.
                if (!soc) begin
                    result_next = '0;
                    mask_next   = MSB_MASK;
                    state_next  = ST_CONV;
                end
            end

            ST_CONV: begin
                // soc is ignored while the search runs.
                result_next = step_result;
                mask_next   = mask_reg >> 1;
                if (mask_reg[0]) begin
                    // Last bit decided: publish the result and signal done together.
                    x_next     = step_result;
                    eoc_next   = 1'b1;
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
                eoc_next   = 1'b1;
            end
        endcase
    end

    assign eoc = eoc_reg;
    assign x   = x_reg;

endmodule

// File: tb/tb_sar_converter.sv
// tb_sar_converter: directed bench for sar_converter (N = 8).
// A transaction-level model predicts eoc/x every clock; a compare process
// checks the DUT against it, and directed literal checks pin the model.

module tb_sar_converter;

    localparam int N = 8;

    logic         clock;
    logic         reset_;
    logic         soc;
    logic [N-1:0] vin;
    logic         eoc;
    logic [N-1:0] x;

    int n_pass  = 0;
    int n_total = 0;
    bit checking = 1'b0;

    sar_converter #(.N(N)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .soc    (soc),
        .vin    (vin),
        .eoc    (eoc),
        .x      (x)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a request is accepted, waits for soc to drop,
    // then takes exactly N clocks and yields the reference value.
    logic         m_busy;
    logic         m_armed;
    int           m_left;
    logic [N-1:0] m_cap;
    logic [N-1:0] m_x;

    always @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            m_busy  <= 1'b0;
            m_armed <= 1'b0;
            m_left  <= 0;
            m_cap   <= '0;
            m_x     <= '0;
        end else if (!m_busy) begin
            if (soc) begin
                m_busy  <= 1'b1;
                m_armed <= 1'b1;
                m_cap   <= vin;
            end
        end else if (m_armed) begin
            if (!soc) begin
                m_armed <= 1'b0;
                m_left  <= N;
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
`ifdef SAR_SAMPLE_HOLD_EN
                m_x <= m_cap;
`else
                m_x <= vin;
`endif
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clock) begin
        if (checking && reset_) begin
            chk("model_eoc", 32'(eoc), 32'(!m_busy));
            chk("model_x", 32'(x), 32'(m_x));
        end
    end

    // Full requester handshake. v0 is presented with soc, v1 replaces it when
    // soc drops. prev_x must be held until completion; exp_x is the result.
    task automatic do_conv(input logic [N-1:0] v0, input logic [N-1:0] v1,
                           input logic [N-1:0] exp_x, input logic [N-1:0] prev_x,
                           input int stall, output int period);
        int total;
        int lat;
        bit seen;
        @(negedge clock);
        vin   = v0;
        soc   = 1'b1;
        total = 0;
        seen  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            total++;
            if (eoc == 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("eoc_fall_timeout", 32'(eoc), 32'd0);
        chk("eoc_fall_delay", 32'(total), 32'd1);
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            total++;
            chk("stall_eoc", 32'(eoc), 32'd0);
            chk("stall_x", 32'(x), 32'(prev_x));
        end
        vin  = v1;
        soc  = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            total++;
            lat++;
            if (eoc == 1'b1) begin
                seen = 1'b1;
                break;
            end
            chk("hold_x", 32'(x), 32'(prev_x));
        end
        if (!seen) chk("eoc_rise_timeout", 32'(eoc), 32'd1);
        chk("latency", 32'(lat - 1), 32'(N));
        chk("result", 32'(x), 32'(exp_x));
        period = total;
        $display("conv vin=0x%02h->0x%02h stall=%0d x=0x%02h latency=%0d period=%0d",
                 v0, v1, stall, x, lat - 1, total);
    endtask

    initial begin
        int p_a5, p;
        int cnt;
        bit seen;
        logic [N-1:0] exp_sh;
        logic [N-1:0] exp_rs;

        reset_ = 1'b0;
        soc    = 1'b0;
        vin    = '0;
        repeat (3) @(negedge clock);
        chk("reset_eoc", 32'(eoc), 32'd1);
        chk("reset_x", 32'(x), 32'd0);
        reset_ = 1'b1;
        checking = 1'b1;
        repeat (3) @(negedge clock);
        chk("idle_eoc", 32'(eoc), 32'd1);

        // Nominal and extreme values, each with the same latency and period.
        do_conv(8'hA5, 8'hA5, 8'hA5, 8'h00, 0, p_a5);
        chk("period_a5", 32'(p_a5), 32'(N + 2));
        do_conv(8'h00, 8'h00, 8'h00, 8'hA5, 0, p);
        chk("period_00", 32'(p), 32'(p_a5));
        do_conv(8'hFF, 8'hFF, 8'hFF, 8'h00, 0, p);
        chk("period_ff", 32'(p), 32'(p_a5));
        do_conv(8'h80, 8'h80, 8'h80, 8'hFF, 0, p);
        chk("period_80", 32'(p), 32'(p_a5));

        // Requester holds soc for 10 clocks after eoc falls.
        do_conv(8'h5A, 8'h5A, 8'h5A, 8'h80, 10, p);

        // vin changes once the request has been accepted.
`ifdef SAR_SAMPLE_HOLD_EN
        exp_sh = 8'h3C;
`else
        exp_sh = 8'h00;
`endif
        do_conv(8'h3C, 8'h00, exp_sh, 8'h5A, 0, p);

        // Result persistence across a following conversion.
        do_conv(8'h3C, 8'h3C, 8'h3C, exp_sh, 0, p);
        do_conv(8'hC3, 8'hC3, 8'hC3, 8'h3C, 0, p);

        // soc raised during the search: ignored until idle, then restarts at once.
        @(negedge clock);
        vin = 8'h11;
        soc = 1'b1;
        @(negedge clock);
        chk("rs_busy", 32'(eoc), 32'd0);
        soc = 1'b0;
        repeat (3) @(negedge clock);
        soc = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (eoc == 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("rs_timeout", 32'(eoc), 32'd1);
        chk("rs_first_x", 32'(x), 32'h11);
        @(negedge clock);
        chk("rs_restart", 32'(eoc), 32'd0);
        vin = 8'h22;
        soc = 1'b0;
`ifdef SAR_SAMPLE_HOLD_EN
        exp_rs = 8'h11;
`else
        exp_rs = 8'h22;
`endif
        cnt  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            cnt++;
            if (eoc == 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("rs2_timeout", 32'(eoc), 32'd1);
        chk("rs_second_x", 32'(x), 32'(exp_rs));
        chk("rs_latency", 32'(cnt - 1), 32'(N));
        $display("restart conv x=0x%02h latency=%0d", x, cnt - 1);

        // Asynchronous reset in the middle of a search.
        @(negedge clock);
        vin = 8'hA5;
        soc = 1'b1;
        @(negedge clock);
        soc = 1'b0;
        repeat (4) @(negedge clock);
        chk("pre_reset_busy", 32'(eoc), 32'd0);
        #2 reset_ = 1'b0;
        #1;
        chk("async_reset_eoc", 32'(eoc), 32'd1);
        chk("async_reset_x", 32'(x), 32'd0);
        @(negedge clock);
        reset_ = 1'b1;
        repeat (N + 4) @(negedge clock);
        chk("post_reset_eoc", 32'(eoc), 32'd1);
        chk("post_reset_x", 32'(x), 32'd0);
        $display("reset mid-conversion eoc=%0b x=0x%02h", eoc, x);

        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
